load_store_buffer: RTL

- In-order load/store queue in the Tomasulo back end. Sits directly upstream of the memory unit.
- Accepts memory ops from the issue stage and holds them until operands arrive on the CDB.
- Dispatches the oldest op to the memory unit once its operands are ready and the unit is idle. Supplies base, offset, op, store data and CDB label.

---
 rtl/load_store_buffer_if.sv | 44 ++++
 rtl/load_store_buffer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/load_store_buffer_if.sv
// Issue, CDB and memory-unit bundle for the load/store buffer.
// The buffer takes the slave side; the issue/CDB/memory side is master.
interface load_store_buffer_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic              issue_ready;
    logic              issue_op;
    logic [TAG_W-1:0]  issue_label;
    logic [TAG_W-1:0]  issue_qj;
    logic [DATA_W-1:0] issue_vj;
    logic [TAG_W-1:0]  issue_qk;
    logic [DATA_W-1:0] issue_vk;
    logic [DATA_W-1:0] issue_imm;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_label;
    logic [DATA_W-1:0] cdb_data;

    logic              mem_busy;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_base;
    logic [DATA_W-1:0] mem_offset;
    logic              mem_op;
    logic [DATA_W-1:0] mem_wdata;
    logic [TAG_W-1:0]  mem_label;

    modport master (
        output issue_valid, issue_op, issue_label, issue_qj, issue_vj,
        output issue_qk, issue_vk, issue_imm,
        output cdb_valid, cdb_label, cdb_data, mem_busy,
        input  issue_ready, mem_wen, mem_base, mem_offset, mem_op,
        input  mem_wdata, mem_label
    );

    modport slave (
        input  issue_valid, issue_op, issue_label, issue_qj, issue_vj,
        input  issue_qk, issue_vk, issue_imm,
        input  cdb_valid, cdb_label, cdb_data, mem_busy,
        output issue_ready, mem_wen, mem_base, mem_offset, mem_op,
        output mem_wdata, mem_label
    );
endinterface

// File: rtl/load_store_buffer.sv
// In-order load/store queue feeding the memory unit, with CDB operand capture.
// Define LSB_STATUS_EN to add the lsb_count / head_stalled status outputs.
module load_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    load_store_buffer_if.slave      bus
`ifdef LSB_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]  lsb_count,
    output logic                    head_stalled
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic              op;
        logic [TAG_W-1:0]  label;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qk;
        logic [DATA_W-1:0] vk;
        logic [DATA_W-1:0] imm;
    } entry_t;

    entry_t           entries [DEPTH];
    entry_t           newEntry;
    entry_t           headEntry;
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [PTR_W:0]   count;
    logic             cdbLive;
    logic             notEmpty;
    logic             headReady;
    logic             doEnq;
    logic             doDeq;

    assign cdbLive   = bus.cdb_valid && (bus.cdb_label != '0);
    assign notEmpty  = (count != '0);
    assign headEntry = entries[headPtr];
    assign headReady = notEmpty && (headEntry.qj == '0)
                     && (headEntry.op || (headEntry.qk == '0));

    assign bus.issue_ready = (count < FULL_CNT);
    assign bus.mem_wen     = headReady && !bus.mem_busy && !rst;
    assign doEnq           = bus.issue_valid && bus.issue_ready;
    assign doDeq           = bus.mem_wen;

    assign bus.mem_base   = notEmpty ? headEntry.vj    : '0;
    assign bus.mem_offset = notEmpty ? headEntry.imm   : '0;
    assign bus.mem_op     = notEmpty ? headEntry.op    : 1'b0;
    assign bus.mem_wdata  = notEmpty ? headEntry.vk    : '0;
    assign bus.mem_label  = notEmpty ? headEntry.label : '0;

    // An op issued alongside a matching broadcast takes the value directly.
    always_comb begin
        newEntry       = '0;
        newEntry.op    = bus.issue_op;
        newEntry.label = bus.issue_label;
        newEntry.imm   = bus.issue_imm;
        newEntry.qj    = bus.issue_qj;
        newEntry.vj    = bus.issue_vj;
        newEntry.qk    = bus.issue_qk;
        newEntry.vk    = bus.issue_vk;
        if (cdbLive && (bus.issue_qj == bus.cdb_label)) begin
            newEntry.qj = '0;
            newEntry.vj = bus.cdb_data;
        end
        if (bus.issue_op) begin
            newEntry.qk = '0;
        end else if (cdbLive && (bus.issue_qk == bus.cdb_label)) begin
            newEntry.qk = '0;
            newEntry.vk = bus.cdb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (cdbLive) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries[i].qj == bus.cdb_label) begin
                        entries[i].qj <= '0;
                        entries[i].vj <= bus.cdb_data;
                    end
                    if (entries[i].qk == bus.cdb_label) begin
                        entries[i].qk <= '0;
                        entries[i].vk <= bus.cdb_data;
                    end
                end
            end
            if (doEnq) begin
                entries[tailPtr] <= newEntry;
                tailPtr          <= tailPtr + PTR_W'(1);
            end
            if (doDeq) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            unique case ({doEnq, doDeq})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef LSB_STATUS_EN
    assign lsb_count    = count;
    assign head_stalled = notEmpty && !bus.mem_wen;
`endif

endmodule
